seq_multiplier: RTL and testbench

- Iterative radix-2 shift-add multiplier for N-bit operands, producing a 2N-bit product.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Uses valid/ready handshakes on both input and output, so it can sit between streaming producers and consumers.
- It is the area-optimised successor to the single-cycle registered multiplier: one adder instead of an N×N array, N iterations per product.

---
 rtl/seq_multiplier_if.sv | 40 ++++
 rtl/seq_multiplier.sv | 112 +++++++++++
 tb/tb_seq_multiplier.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Handshake bundle for seq_multiplier: operand side (A, B, mode, valid/ready)
// and product side (P_out, valid/ready) plus the Busy status flag.
// slave = the multiplier; master = the producer/consumer driving it.
interface seq_multiplier_if #(
    parameter int N = 8
);
    logic [N-1:0]   Data_in_A;
    logic [N-1:0]   Data_in_B;
    logic           Signed_mode;
    logic           In_valid;
    logic           In_ready;
    logic [2*N-1:0] P_out;
    logic           Out_valid;
    logic           Out_ready;
    logic           Busy;

    modport slave (
        input  Data_in_A,
        input  Data_in_B,
        input  Signed_mode,
        input  In_valid,
        output In_ready,
        output P_out,
        output Out_valid,
        input  Out_ready,
        output Busy
    );

    modport master (
        output Data_in_A,
        output Data_in_B,
        output Signed_mode,
        output In_valid,
        input  In_ready,
        input  P_out,
        input  Out_valid,
        output Out_ready,
        input  Busy
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier, N x N -> 2N, unsigned or signed per operation.
// Latency: Out_valid rises N cycles after the accept edge; II = N+2 with Out_ready held high.
// Backpressure: product held in DONE while Out_ready = 0; In_ready only in IDLE.
// Ports: clk, Reset_n (async active-low), bus (seq_multiplier_if.slave):
//   Data_in_A/Data_in_B/Signed_mode/In_valid/In_ready in, P_out/Out_valid/Out_ready out, Busy.
module seq_multiplier #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            Reset_n,
    seq_multiplier_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state;
    state_t         state_nxt;
    logic [2*N-1:0] mcand;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_nxt;
    logic [2*N-1:0] p_reg;
    logic [N-1:0]   mplr;
    logic [N-1:0]   abs_a;
    logic [N-1:0]   abs_b;
    logic           neg;
    logic [CW-1:0]  count;
    logic           last;

    // Magnitudes are taken as N-bit unsigned values, so -2^(N-1) maps
    // cleanly onto 2^(N-1); the sign is reapplied once at the end.
    always_comb begin
        abs_a = bus.Data_in_A;
        abs_b = bus.Data_in_B;
        if (bus.Signed_mode && bus.Data_in_A[N-1]) begin
            abs_a = -bus.Data_in_A;
        end
        if (bus.Signed_mode && bus.Data_in_B[N-1]) begin
            abs_b = -bus.Data_in_B;
        end
    end

    // The single adder: this cycle's partial sum, also used for the final
    // product so the last iteration's addition is included.
    assign acc_nxt = acc + (mplr[0] ? mcand : '0);
    assign last    = (count == LAST);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.In_valid)  state_nxt = CALC;
            CALC:    if (last)          state_nxt = DONE;
            DONE:    if (bus.Out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            count <= '0;
            p_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.In_valid) begin
                        mcand <= {{N{1'b0}}, abs_a};
                        mplr  <= abs_b;
                        neg   <= bus.Signed_mode & (bus.Data_in_A[N-1] ^ bus.Data_in_B[N-1]);
                        acc   <= '0;
                        count <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    count <= count + CW'(1);
                    if (last) begin
                        p_reg <= neg ? -acc_nxt : acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs decode from state only; P_out is a register.
    assign bus.In_ready  = (state == IDLE);
    assign bus.Out_valid = (state == DONE);
    assign bus.Busy      = (state != IDLE);
    assign bus.P_out     = p_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier (N = 8): directed products, backpressure,
// reset during an operation and a back-to-back random stream against a
// plain-arithmetic reference model.
module tb_seq_multiplier;

    localparam int N = 8;

    logic clk;
    logic Reset_n;
    int   compared;
    int   mismatched;

    seq_multiplier_if #(.N(N)) bus ();

    seq_multiplier #(.N(N)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret operands as integers and multiply.
    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input logic s);
        logic signed [N-1:0] sa;
        logic signed [N-1:0] sb;
        longint xa;
        longint xb;
        sa = a;
        sb = b;
        xa = s ? longint'(sa) : longint'(a);
        xb = s ? longint'(sb) : longint'(b);
        return (2*N)'(xa * xb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, let it be accepted, then wait (bounded) for Out_valid.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          output logic [2*N-1:0] p, output int lat, output bit timed_out);
        bus.Data_in_A   = a;
        bus.Data_in_B   = b;
        bus.Signed_mode = s;
        bus.In_valid    = 1'b1;
        tick();
        bus.In_valid = 1'b0;
        lat       = 0;
        timed_out = 1'b1;
        for (int i = 1; i <= N + 10; i++) begin
            tick();
            if (bus.Out_valid === 1'b1) begin
                lat       = i;
                timed_out = 1'b0;
                break;
            end
        end
        p = bus.P_out;
    endtask

    task automatic test_reset();
        Reset_n = 1'b1;
        #3;
        Reset_n = 1'b0;
        #1;
        compared++;
        if ({bus.P_out, bus.Out_valid, bus.In_ready, bus.Busy} !== {16'h0000, 3'b010}) begin
            mismatched++;
            $display("FAIL reset_assert: P_out=%h Out_valid=%b In_ready=%b Busy=%b, need 0000 0 1 0",
                     bus.P_out, bus.Out_valid, bus.In_ready, bus.Busy);
        end
        tick();
        tick();
        @(negedge clk);
        Reset_n = 1'b1;
        repeat (5) tick();
        compared++;
        if ({bus.P_out, bus.Out_valid, bus.In_ready, bus.Busy} !== {16'h0000, 3'b010}) begin
            mismatched++;
            $display("FAIL reset_release: P_out=%h Out_valid=%b In_ready=%b Busy=%b, need 0000 0 1 0",
                     bus.P_out, bus.Out_valid, bus.In_ready, bus.Busy);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0]   ta [8] = '{8'd13, 8'd255, 8'd0,   8'hFD, 8'h80, 8'h80, 8'hFF, 8'h05};
        logic [N-1:0]   tb [8] = '{8'd11, 8'd255, 8'd200, 8'h05, 8'h80, 8'h7F, 8'hFF, 8'hFD};
        logic           ts [8] = '{1'b0,  1'b0,   1'b0,   1'b1,  1'b1,  1'b1,  1'b1,  1'b1};
        logic [2*N-1:0] te [8] = '{16'h008F, 16'hFE01, 16'h0000, 16'hFFF1,
                                   16'h4000, 16'hC080, 16'h0001, 16'hFFF1};
        logic [2*N-1:0] p;
        int             lat;
        bit             to;
        for (int k = 0; k < 8; k++) begin
            compared++;
            if (bus.In_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL directed_ready[%0d]: In_ready=%b, need 1", k, bus.In_ready);
            end
            run_op(ta[k], tb[k], ts[k], p, lat, to);
            compared++;
            if (to || lat != N) begin
                mismatched++;
                $display("FAIL directed_latency[%0d]: got %0d cycles (timeout=%0d), need %0d",
                         k, lat, to, N);
            end
            compared++;
            if (p !== te[k]) begin
                mismatched++;
                $display("FAIL directed_product[%0d]: %h x %h s=%b got %h, need %h",
                         k, ta[k], tb[k], ts[k], p, te[k]);
            end
            bus.Out_ready = 1'b1;
            tick();
            bus.Out_ready = 1'b0;
            compared++;
            if ({bus.Out_valid, bus.In_ready, bus.P_out} !== {2'b01, te[k]}) begin
                mismatched++;
                $display("FAIL directed_handoff[%0d]: Out_valid=%b In_ready=%b P_out=%h, need 0 1 %h",
                         k, bus.Out_valid, bus.In_ready, bus.P_out, te[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [N-1:0]   a2;
        logic [N-1:0]   b2;
        logic           s2;
        logic [2*N-1:0] exp;
        logic [2*N-1:0] p;
        int             lat;
        bit             to;
        a   = N'($urandom_range(1, 255));
        b   = N'($urandom_range(1, 255));
        exp = ref_mul(a, b, 1'b0);
        run_op(a, b, 1'b0, p, lat, to);
        compared++;
        if (to || p !== exp) begin
            mismatched++;
            $display("FAIL bp_product: got %h (timeout=%0d), need %h", p, to, exp);
        end
        // A new request arriving during DONE must wait for IDLE.
        a2 = N'($urandom_range(1, 255));
        b2 = N'($urandom_range(1, 255));
        s2 = 1'($urandom_range(0, 1));
        bus.Data_in_A   = a2;
        bus.Data_in_B   = b2;
        bus.Signed_mode = s2;
        bus.In_valid    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            compared++;
            if ({bus.Out_valid, bus.In_ready, bus.Busy, bus.P_out} !== {3'b101, exp}) begin
                mismatched++;
                $display("FAIL bp_hold[%0d]: Out_valid=%b In_ready=%b Busy=%b P_out=%h, need 1 0 1 %h",
                         i, bus.Out_valid, bus.In_ready, bus.Busy, bus.P_out, exp);
            end
        end
        bus.Out_ready = 1'b1;
        tick();
        bus.Out_ready = 1'b0;
        compared++;
        if ({bus.Out_valid, bus.In_ready, bus.Busy, bus.P_out} !== {3'b010, exp}) begin
            mismatched++;
            $display("FAIL bp_release: Out_valid=%b In_ready=%b Busy=%b P_out=%h, need 0 1 0 %h",
                     bus.Out_valid, bus.In_ready, bus.Busy, bus.P_out, exp);
        end
        // The held request is taken on this edge.
        run_op(a2, b2, s2, p, lat, to);
        compared++;
        if (to || lat != N || p !== ref_mul(a2, b2, s2)) begin
            mismatched++;
            $display("FAIL bp_second: got %h lat=%0d (timeout=%0d), need %h lat=%0d",
                     p, lat, to, ref_mul(a2, b2, s2), N);
        end
        bus.Out_ready = 1'b1;
        tick();
        bus.Out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [2*N-1:0] p;
        int             lat;
        bit             to;
        bus.Data_in_A   = 8'd100;
        bus.Data_in_B   = 8'd3;
        bus.Signed_mode = 1'b0;
        bus.In_valid    = 1'b1;
        tick();
        bus.In_valid = 1'b0;
        repeat (4) tick();
        compared++;
        if (bus.Busy !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst_busy: Busy=%b before reset, need 1", bus.Busy);
        end
        Reset_n = 1'b0;
        #1;
        compared++;
        if ({bus.P_out, bus.Out_valid, bus.In_ready, bus.Busy} !== {16'h0000, 3'b010}) begin
            mismatched++;
            $display("FAIL midrst_async: P_out=%h Out_valid=%b In_ready=%b Busy=%b, need 0000 0 1 0",
                     bus.P_out, bus.Out_valid, bus.In_ready, bus.Busy);
        end
        tick();
        @(negedge clk);
        Reset_n = 1'b1;
        tick();
        run_op(8'd7, 8'd9, 1'b0, p, lat, to);
        compared++;
        if (to || lat != N || p !== 16'h003F) begin
            mismatched++;
            $display("FAIL midrst_after: got %h lat=%0d (timeout=%0d), need 003f lat=%0d",
                     p, lat, to, N);
        end
        bus.Out_ready = 1'b1;
        tick();
        bus.Out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] expq[$];
        int             sent;
        int             recv;
        int             last_cyc;
        bit             acc;
        logic [2*N-1:0] e;
        sent     = 0;
        recv     = 0;
        last_cyc = -1;
        bus.Out_ready   = 1'b1;
        bus.Data_in_A   = N'($urandom);
        bus.Data_in_B   = N'($urandom);
        bus.Signed_mode = 1'($urandom_range(0, 1));
        bus.In_valid    = 1'b1;
        for (int cyc = 0; cyc < 20 * (N + 2) + 60; cyc++) begin
            acc = bus.In_valid && bus.In_ready;
            if (acc) begin
                expq.push_back(ref_mul(bus.Data_in_A, bus.Data_in_B, bus.Signed_mode));
                sent++;
            end
            tick();
            if (acc) begin
                if (sent == 20) begin
                    bus.In_valid = 1'b0;
                end else begin
                    bus.Data_in_A   = N'($urandom);
                    bus.Data_in_B   = N'($urandom);
                    bus.Signed_mode = 1'($urandom_range(0, 1));
                end
            end
            if (bus.Out_valid === 1'b1) begin
                compared++;
                if (expq.size() == 0) begin
                    mismatched++;
                    $display("FAIL b2b_extra: unexpected product %h at cycle %0d", bus.P_out, cyc);
                end else begin
                    e = expq.pop_front();
                    if (bus.P_out !== e) begin
                        mismatched++;
                        $display("FAIL b2b_product[%0d]: got %h, need %h", recv, bus.P_out, e);
                    end
                end
                if (last_cyc >= 0) begin
                    compared++;
                    if (cyc - last_cyc != N + 2) begin
                        mismatched++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles, need %0d",
                                 recv, cyc - last_cyc, N + 2);
                    end
                end
                last_cyc = cyc;
                recv++;
                if (recv == 20) break;
            end
        end
        compared++;
        if (recv != 20 || expq.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_count: received %0d with %0d outstanding, need 20 with 0",
                     recv, expq.size());
        end
        bus.In_valid  = 1'b0;
        bus.Out_ready = 1'b0;
        tick();
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        bus.Data_in_A   = '0;
        bus.Data_in_B   = '0;
        bus.Signed_mode = 1'b0;
        bus.In_valid    = 1'b0;
        bus.Out_ready   = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
